// File: rtl/cpu_move_engine_if.sv
// Controller <-> CPU move engine bus: board snapshot in, single-cell write and
// completion handshake out.
interface cpu_move_engine_if;
  logic        clr;
  logic        cpu_input_en;
  logic [17:0] board;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [1:0]  wr_data;
  logic        cpu_done;
  logic        no_move;
  logic        busy;

  modport master (
    output clr, cpu_input_en, board,
    input  wr_en, wr_addr, wr_data, cpu_done, no_move, busy
  );

  modport slave (
    input  clr, cpu_input_en, board,
    output wr_en, wr_addr, wr_data, cpu_done, no_move, busy
  );
endinterface

// File: rtl/cpu_move_engine.sv
// Tic-tac-toe computer opponent: scans a board snapshot for a winning line, then a
// blocking line, then falls back to positional priority, and writes one CPU mark.
module cpu_move_engine #(
  parameter logic [1:0] CPU_CODE    = 2'b10,
  parameter logic [1:0] PLAYER_CODE = 2'b01
) (
  input logic            clk,
  input logic            rst,
  cpu_move_engine_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, SCAN_WIN, SCAN_BLOCK, PICK, WRITE, DONE, WAIT_REL
  } state_t;

  localparam logic [11:0] LINES [8] = '{
    {4'd0, 4'd1, 4'd2}, {4'd3, 4'd4, 4'd5}, {4'd6, 4'd7, 4'd8},
    {4'd0, 4'd3, 4'd6}, {4'd1, 4'd4, 4'd7}, {4'd2, 4'd5, 4'd8},
    {4'd0, 4'd4, 4'd8}, {4'd2, 4'd4, 4'd6}
  };

  localparam logic [3:0] PICK_ORDER [9] = '{
    4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
  };

  state_t      state;
  logic [17:0] snap;
  logic [2:0]  idx;
  logic        wr_en_q;
  logic [3:0]  wr_addr_q;
  logic        cpu_done_q;
  logic        no_move_q;

  logic [3:0]  la, lb, lc;
  logic [1:0]  ca, cb, cc;
  logic [1:0]  target;
  logic        line_hit;
  logic [3:0]  hit_cell;
  logic [8:0]  empty;
  logic        pick_found;
  logic [3:0]  pick_cell;

  // Current line under test: two marks of the target code plus one empty cell.
  always_comb begin
    {la, lb, lc} = LINES[idx];
    ca       = snap[{la, 1'b0} +: 2];
    cb       = snap[{lb, 1'b0} +: 2];
    cc       = snap[{lc, 1'b0} +: 2];
    target   = (state == SCAN_BLOCK) ? PLAYER_CODE : CPU_CODE;
    line_hit = 1'b0;
    hit_cell = 4'd0;
    if (ca == target && cb == target && cc == 2'b00) begin
      line_hit = 1'b1;
      hit_cell = lc;
    end else if (ca == target && cc == target && cb == 2'b00) begin
      line_hit = 1'b1;
      hit_cell = lb;
    end else if (cb == target && cc == target && ca == 2'b00) begin
      line_hit = 1'b1;
      hit_cell = la;
    end
  end

  // Walk the priority list backwards so the earliest empty cell in it wins.
  always_comb begin
    empty      = '0;
    pick_found = 1'b0;
    pick_cell  = 4'd0;
    for (int i = 0; i < 9; i++) begin
      empty[i] = (snap[2*i +: 2] == 2'b00);
    end
    for (int k = 8; k >= 0; k--) begin
      if (empty[PICK_ORDER[k]]) begin
        pick_found = 1'b1;
        pick_cell  = PICK_ORDER[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      snap       <= '0;
      idx        <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      cpu_done_q <= 1'b0;
      no_move_q  <= 1'b0;
    end else if (bus.clr) begin
      state      <= IDLE;
      snap       <= '0;
      idx        <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      cpu_done_q <= 1'b0;
      no_move_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          wr_en_q    <= 1'b0;
          cpu_done_q <= 1'b0;
          no_move_q  <= 1'b0;
          if (bus.cpu_input_en) begin
            snap  <= bus.board;
            idx   <= '0;
            state <= SCAN_WIN;
          end
        end
        SCAN_WIN, SCAN_BLOCK: begin
          if (line_hit) begin
            wr_addr_q <= hit_cell;
            wr_en_q   <= 1'b1;
            state     <= DONE;
          end else if (idx == 3'd7) begin
            idx   <= '0;
            state <= (state == SCAN_WIN) ? SCAN_BLOCK : PICK;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        PICK: begin
          if (pick_found) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= pick_cell;
            state     <= DONE;
          end else begin
            state <= WRITE;
          end
        end
        // Full board: nothing is written, only the completion is reported.
        WRITE: begin
          cpu_done_q <= 1'b1;
          no_move_q  <= 1'b1;
          state      <= WAIT_REL;
        end
        DONE: begin
          wr_en_q    <= 1'b0;
          cpu_done_q <= 1'b1;
          state      <= WAIT_REL;
        end
        WAIT_REL: begin
          cpu_done_q <= 1'b0;
          no_move_q  <= 1'b0;
          if (!bus.cpu_input_en) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = CPU_CODE;
  assign bus.cpu_done = cpu_done_q;
  assign bus.no_move  = no_move_q;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_cpu_move_engine.sv
// Directed bench for cpu_move_engine: win, block and positional moves, full board,
// request hold/drop behaviour, and async reset / sync clear in the middle of a scan.
module tb_cpu_move_engine;

  localparam logic [1:0] CPU = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  cpu_move_engine_if bus();

  cpu_move_engine #(.CPU_CODE(CPU), .PLAYER_CODE(2'b01)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [17:0] b);
    @(negedge clk);
    bus.board        = b;
    bus.cpu_input_en = 1'b1;
  endtask

  // Issues one request and watches 25 edges after E0; the board is scrambled after E0.
  task automatic runMove(input string tag, input logic [17:0] b, input int hold,
                         input int dropAt, input int expWr, input int expAddr,
                         input int expDone, input logic expNm);
    int         wrEdge   = -1;
    int         doneEdge = -1;
    int         wrCount  = 0;
    logic [3:0] addr     = '0;
    logic       nm       = 1'b0;
    logic       overlap  = 1'b0;
    applyStimulus(b);
    @(posedge clk);
    #1 bus.board = ~b;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk);
      #1;
      if (bus.wr_en) begin
        wrCount++;
        if (wrEdge < 0) begin
          wrEdge = n;
          addr   = bus.wr_addr;
        end
      end
      if (bus.cpu_done && doneEdge < 0) begin
        doneEdge = n;
        nm       = bus.no_move;
      end
      if (bus.wr_en && bus.cpu_done) overlap = 1'b1;
      if (n == dropAt) bus.cpu_input_en = 1'b0;
      if (doneEdge > 0 && n >= doneEdge + hold) bus.cpu_input_en = 1'b0;
    end
    bus.cpu_input_en = 1'b0;
    if (expWr < 0) begin
      checkOutput({tag, " wr_count"}, wrCount, 0);
    end else begin
      checkOutput({tag, " wr_edge"}, wrEdge, expWr);
      checkOutput({tag, " wr_addr"}, {28'd0, addr}, expAddr);
      checkOutput({tag, " wr_count"}, wrCount, 1);
    end
    checkOutput({tag, " done_edge"}, doneEdge, expDone);
    checkOutput({tag, " no_move"}, {31'd0, nm}, {31'd0, expNm});
    checkOutput({tag, " overlap"}, {31'd0, overlap}, 0);
    checkOutput({tag, " idle"}, {31'd0, bus.busy}, 0);
  endtask

  initial begin
    int writes;
    bus.clr          = 1'b0;
    bus.cpu_input_en = 1'b0;
    bus.board        = '0;

    #12;
    checkOutput("reset busy", {31'd0, bus.busy}, 0);
    checkOutput("reset wr_en", {31'd0, bus.wr_en}, 0);
    checkOutput("reset wr_addr", {28'd0, bus.wr_addr}, 0);
    checkOutput("reset cpu_done", {31'd0, bus.cpu_done}, 0);
    checkOutput("reset no_move", {31'd0, bus.no_move}, 0);
    checkOutput("wr_data", {30'd0, bus.wr_data}, {30'd0, CPU});
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed moves");
    runMove("win line0",    18'h0000A, 3, 0,  1, 2,  2, 1'b0);
    runMove("block line1",  18'h00142, 1, 0, 10, 5, 11, 1'b0);
    runMove("win over blk", 18'h0A005, 1, 0,  3, 8,  4, 1'b0);
    runMove("win line7",    18'h02020, 1, 0,  8, 4,  9, 1'b0);
    runMove("block line7",  18'h00110, 1, 0, 16, 6, 17, 1'b0);
    runMove("empty board",  18'h00000, 1, 0, 17, 4, 18, 1'b0);
    runMove("only cell7",   18'h21666, 2, 0, 17, 7, 18, 1'b0);
    runMove("full board",   18'h3FFFF, 1, 0, -1, 0, 18, 1'b1);
    runMove("drop midscan", 18'h00000, 1, 3, 17, 4, 18, 1'b0);

    $display("[TB] async reset mid-scan");
    applyStimulus(18'h0);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst busy", {31'd0, bus.busy}, 0);
    checkOutput("rst wr_en", {31'd0, bus.wr_en}, 0);
    checkOutput("rst cpu_done", {31'd0, bus.cpu_done}, 0);
    bus.cpu_input_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    writes = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.wr_en || bus.cpu_done) writes++;
    end
    checkOutput("rst no write", writes, 0);

    $display("[TB] sync clear mid-scan");
    applyStimulus(18'h0);
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.clr = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("clr busy", {31'd0, bus.busy}, 0);
    checkOutput("clr wr_addr", {28'd0, bus.wr_addr}, 0);
    checkOutput("clr wr_en", {31'd0, bus.wr_en}, 0);
    @(negedge clk);
    bus.clr          = 1'b0;
    bus.cpu_input_en = 1'b0;
    writes = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.wr_en || bus.cpu_done) writes++;
    end
    checkOutput("clr no write", writes, 0);

    runMove("after clr", 18'h0000A, 1, 0, 1, 2, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
